ring_stimulus_generator: RTL and testbench
==========================================

# ring_stimulus_generator

Programmable square-wave generator that drives a known-frequency test signal into the ring-oscillator counting path, giving the frequency counter a calibrated source. The output toggles every `half_period` clock cycles, so output frequency is f_clk / (2·half_period). It sits beside the counting circuit on the same board clock; its `wave_out` replaces the ring input during calibration. It also reports how many rising edges it has emitted, so the bench can compare against the counter's reading.

## Interface
- `WIDTH`, 16: width of the half-period register.
- `CNT_WIDTH`, 16: width of `pulse_count` and `burst_len`.

- `clk`  input  1  system clock; all logic on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `enable`  input  1  1 = generator advances; 0 = freeze (counter and `wave_out` hold).
- `load`  input  1  one-cycle strobe; captures `half_period` into `hp_reg`.
- `half_period`  input  WIDTH  clk cycles per output half-period; 0 is treated as 1.
- `start`  input  1  one-cycle strobe; begins generation from IDLE.
- `stop`  input  1  one-cycle strobe; aborts generation.
- `burst_len`  input  CNT_WIDTH  rising edges to emit; 0 = continuous (burst build only).
- `wave_out`  output  1  generated square wave, registered.
- `pulse_count`  output  CNT_WIDTH  rising edges emitted since last start; saturates at all-ones.
- `busy`  output  1  1 while in RUN.
- `done`  output  1  one-cycle pulse on burst completion.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE, `wave_out`=0, `pulse_count`=0, `busy`=0, `done`=0, `hp_reg`=1, phase counter=0.
- `load`: accepted in any state; `hp_reg` <= max(`half_period`,1). In RUN the new value takes effect at the next toggle; the current half-period completes with the old value.
- IDLE: `wave_out`=0. `start` → RUN; clears `pulse_count` and phase counter; samples `burst_len`.
- RUN, `enable`=1: phase counter increments each cycle. When it reaches `hp_reg`-1 it resets to 0 and `wave_out` toggles. A 0→1 toggle increments `pulse_count`, which saturates and does not wrap.
- RUN, `enable`=0: all state holds; `stop` still acts.
- Burst completion: after the `burst_len`-th rising edge, the next falling toggle moves the state to DONE.
- DONE: lasts one cycle with `done`=1, `busy`=0, then IDLE. `pulse_count` holds until the next `start`.
- `stop` in RUN or DONE → IDLE next edge; `wave_out` forced 0; `done` not asserted; `pulse_count` holds.
- `start` while in RUN or DONE is ignored.
- Same-cycle conflicts:
  - `stop` and `start`: stop wins.
  - `load` and `start`: the run uses the newly loaded value.
- Reset asserted mid-run: immediate return to reset values, independent of `clk`.

## Timing
- `start` sampled at edge E0 → `busy`=1 after E0.
- First rising `wave_out` after edge E0+`hp_reg`.
- Then a toggle every `hp_reg` edges; period = 2·`hp_reg` cycles.
- `pulse_count` updates on the same edge as the rising `wave_out`.
- `done` is high for exactly the one cycle following the final falling toggle.
- `hp_reg`=1 gives f_clk/2, the maximum output frequency.
- All outputs come directly from flops; there are no combinational input→output paths.

## Configuration
- `RING_GEN_BURST_EN` defined:
  - `burst_len` port present.
  - Burst completion, the DONE state and `done` behave as described above.
- `RING_GEN_BURST_EN` undefined:
  - `burst_len` port absent.
  - Generation is always continuous until `stop`.
  - DONE is unreachable; `done` is tied 0.

## Test plan
- Reset then idle: `rst_n` low for 3 cycles, then high for 10 → all outputs 0, `wave_out` never toggles.
- Continuous run: `load` `half_period`=5, `start`, run 100 cycles → `wave_out` period 10 cycles, first rise at E0+5, `pulse_count`=10.
- Burst (macro on): `half_period`=3, `burst_len`=4, `start` →
  - exactly 4 rising edges;
  - `done`=1 for one cycle at E0+24;
  - `busy`=0 after; `pulse_count`=4.
- Freeze and reload: `half_period`=4, `start`; drop `enable` for 7 cycles mid-half-period → phase resumes with no lost or extra cycles. Then `load` `half_period`=0 → toggling every cycle from the next toggle.
- Abort and conflicts:
  - `stop` mid-run → `wave_out`=0 next edge, no `done`.
  - `start` and `stop` in the same cycle from IDLE → stays IDLE.
  - Async reset during RUN → immediate zeros.
- Loopback: drive `wave_out` into the counting circuit at `half_period`=50 → counted edges match `pulse_count` over the window.

Source files
------------

// File: rtl/ring_stimulus_generator.sv
// Programmable square-wave source for calibrating the ring-oscillator counter.
// Define RING_GEN_BURST_EN to add burst_len, the DONE state and the done pulse.
module ring_stimulus_generator #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 load,
    input  logic [WIDTH-1:0]     half_period,
    input  logic                 start,
    input  logic                 stop,
`ifdef RING_GEN_BURST_EN
    input  logic [CNT_WIDTH-1:0] burst_len,
`endif
    output logic                 wave_out,
    output logic [CNT_WIDTH-1:0] pulse_count,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     hp_q, hp_d;
    logic [WIDTH-1:0]     act_q, act_d;
    logic [WIDTH-1:0]     phase_q, phase_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 wave_q, wave_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 burst_hit;

    // act_q is the half-period in force; hp_q only lands in it at a toggle.
    assign hp_d = load ? ((half_period == '0) ? WIDTH'(1) : half_period)
                       : hp_q;

`ifdef RING_GEN_BURST_EN
    logic [CNT_WIDTH-1:0] burst_q, burst_d;

    assign burst_hit = (burst_q != '0) && (cnt_q >= burst_q);
`else
    assign burst_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        wave_d  = wave_q;
`ifdef RING_GEN_BURST_EN
        burst_d = burst_q;
`endif
        unique case (state_q)
            IDLE: begin
                wave_d = 1'b0;
                if (start && !stop) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    phase_d = '0;
                    act_d   = hp_d;
`ifdef RING_GEN_BURST_EN
                    burst_d = burst_len;
`endif
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    wave_d  = 1'b0;
                end else if (enable) begin
                    if (phase_q == act_q - WIDTH'(1)) begin
                        phase_d = '0;
                        wave_d  = ~wave_q;
                        act_d   = hp_d;
                        if (!wave_q) begin
                            if (!(&cnt_q)) cnt_d = cnt_q + CNT_WIDTH'(1);
                        end else if (burst_hit) begin
                            state_d = DONE;
                        end
                    end else begin
                        phase_d = phase_q + WIDTH'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                wave_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                wave_d  = 1'b0;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hp_q    <= WIDTH'(1);
            act_q   <= WIDTH'(1);
            phase_q <= '0;
            cnt_q   <= '0;
            wave_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RING_GEN_BURST_EN
            burst_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            act_q   <= act_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            wave_q  <= wave_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef RING_GEN_BURST_EN
            burst_q <= burst_d;
`endif
        end
    end

    assign wave_out    = wave_q;
    assign pulse_count = cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_ring_stimulus_generator.sv
// Directed bench for ring_stimulus_generator.
// Burst scenario is exercised only when RING_GEN_BURST_EN is defined.
module tb_ring_stimulus_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] half_period;
    logic        start;
    logic        stop;
`ifdef RING_GEN_BURST_EN
    logic [15:0] burst_len;
`endif
    logic        wave_out;
    logic [15:0] pulse_count;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ring_stimulus_generator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .half_period(half_period),
        .start      (start),
        .stop       (stop),
`ifdef RING_GEN_BURST_EN
        .burst_len  (burst_len),
`endif
        .wave_out   (wave_out),
        .pulse_count(pulse_count),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        load = 1'b0;
        half_period = '0;
        start = 1'b0;
        stop = 1'b0;
`ifdef RING_GEN_BURST_EN
        burst_len = '0;
`endif
        repeat (3) tick();
        checks++;
        if ({wave_out, busy, done, pulse_count} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs: got w=%b b=%b d=%b c=%0d expected all 0",
                     wave_out, busy, done, pulse_count);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if ({wave_out, busy, done, pulse_count} !== 19'd0) begin
                failures++;
                $display("FAIL idle_k%0d: got w=%b b=%b d=%b c=%0d expected all 0",
                         k, wave_out, busy, done, pulse_count);
            end
        end
    endtask

    task automatic test_max_freq();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || wave_out !== 1'b0) begin
            failures++;
            $display("FAIL maxf_start: got b=%b w=%b expected b=1 w=0", busy, wave_out);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (wave_out !== 1'(k % 2) || pulse_count !== 16'((k + 1) / 2)) begin
                failures++;
                $display("FAIL maxf_k%0d: got w=%b c=%0d expected w=%0d c=%0d",
                         k, wave_out, pulse_count, k % 2, (k + 1) / 2);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_continuous();
        half_period = 16'd5;
        load = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || wave_out !== 1'b0 || pulse_count !== 16'd0) begin
            failures++;
            $display("FAIL cont_start: got b=%b w=%b c=%0d expected 1 0 0",
                     busy, wave_out, pulse_count);
        end
        for (int k = 1; k <= 100; k++) begin
            tick();
            checks++;
            if (wave_out !== 1'((k / 5) % 2) ||
                pulse_count !== 16'((k + 5) / 10) || done !== 1'b0) begin
                failures++;
                $display("FAIL cont_k%0d: got w=%b c=%0d d=%b expected w=%0d c=%0d d=0",
                         k, wave_out, pulse_count, done, (k / 5) % 2, (k + 5) / 10);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (wave_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            pulse_count !== 16'd10) begin
            failures++;
            $display("FAIL cont_stop: got w=%b b=%b d=%b c=%0d expected 0 0 0 10",
                     wave_out, busy, done, pulse_count);
        end
    endtask

`ifdef RING_GEN_BURST_EN
    task automatic test_burst();
        int rises;
        logic prev;
        logic ew;
        int ec;
        rises = 0;
        prev = 1'b0;
        half_period = 16'd3;
        burst_len = 16'd4;
        load = 1'b1;
        start = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            ew = (k < 24) && ((k / 3) % 2 == 1);
            ec = ((k + 3) / 6 > 4) ? 4 : (k + 3) / 6;
            if (wave_out === 1'b1 && prev === 1'b0) rises++;
            prev = wave_out;
            checks++;
            if (wave_out !== ew || done !== 1'(k == 24) ||
                busy !== 1'(k < 24) || pulse_count !== 16'(ec)) begin
                failures++;
                $display("FAIL burst_k%0d: got w=%b d=%b b=%b c=%0d expected w=%b d=%0d b=%0d c=%0d",
                         k, wave_out, done, busy, pulse_count, ew, k == 24, k < 24, ec);
            end
        end
        checks++;
        if (rises != 4) begin
            failures++;
            $display("FAIL burst_rises: got %0d expected 4", rises);
        end
        burst_len = '0;
    endtask
`endif

    task automatic test_freeze_reload();
        int e;
        logic ew;
        logic pw;
        int ec;
        pw = 1'b0;
        ec = 0;
        half_period = 16'd4;
        load = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            enable = !(k >= 3 && k <= 9);
            load = (k == 21);
            half_period = (k == 21) ? 16'd0 : 16'd4;
            tick();
            load = 1'b0;
            e = (k <= 2) ? k : ((k <= 9) ? 2 : k - 7);
            if (k <= 22) ew = 1'((e / 4) % 2);
            else ew = 1'((k - 23) % 2);
            if (ew && !pw) ec++;
            pw = ew;
            checks++;
            if (wave_out !== ew || pulse_count !== 16'(ec)) begin
                failures++;
                $display("FAIL freeze_k%0d: got w=%b c=%0d expected w=%b c=%0d",
                         k, wave_out, pulse_count, ew, ec);
            end
        end
        enable = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_abort();
        half_period = 16'd2;
        load = 1'b1;
        start = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if (wave_out !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre: got w=%b b=%b expected 1 1", wave_out, busy);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (wave_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            pulse_count !== 16'd1) begin
            failures++;
            $display("FAIL abort_stop: got w=%b b=%b d=%b c=%0d expected 0 0 0 1",
                     wave_out, busy, done, pulse_count);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (wave_out !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL abort_after_k%0d: got w=%b d=%b expected 0 0",
                         k, wave_out, done);
            end
        end
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || wave_out !== 1'b0 || pulse_count !== 16'd1) begin
            failures++;
            $display("FAIL start_stop: got b=%b w=%b c=%0d expected 0 0 1",
                     busy, wave_out, pulse_count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if (wave_out !== 1'b1 || busy !== 1'b1 || pulse_count !== 16'd1) begin
            failures++;
            $display("FAIL async_pre: got w=%b b=%b c=%0d expected 1 1 1",
                     wave_out, busy, pulse_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wave_out, busy, done, pulse_count} !== 19'd0) begin
            failures++;
            $display("FAIL async_reset: got w=%b b=%b d=%b c=%0d expected all 0",
                     wave_out, busy, done, pulse_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({wave_out, busy, done, pulse_count} !== 19'd0) begin
            failures++;
            $display("FAIL async_release: got w=%b b=%b d=%b c=%0d expected all 0",
                     wave_out, busy, done, pulse_count);
        end
    endtask

    task automatic test_loopback();
        int edges;
        logic prev;
        edges = 0;
        prev = 1'b0;
        half_period = 16'd50;
        load = 1'b1;
        start = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (wave_out === 1'b1 && prev === 1'b0) edges++;
            prev = wave_out;
        end
        checks++;
        if (edges != 3 || pulse_count !== 16'd3) begin
            failures++;
            $display("FAIL loopback: got edges=%0d c=%0d expected 3 3",
                     edges, pulse_count);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_max_freq();
        test_continuous();
`ifdef RING_GEN_BURST_EN
        test_burst();
`endif
        test_freeze_reload();
        test_abort();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
